// File: rtl/axis_tail_overlap_dec.sv
// Tail-overlap decoder: removes the reversed tail of the previous packet
// that the upstream adder folded into the head of the current packet.
module axis_tail_overlap_dec #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH:0]   s_axis_data,
  input  logic                  s_axis_valid,
  input  logic                  s_axis_last,
  output logic                  s_axis_ready,
  input  logic [DATA_WIDTH-1:0] packet_length,
  input  logic [DATA_WIDTH-1:0] k,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic                  short_pkt
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] p_q, p_d;
  logic [DW-1:0] len_q, len_d;
  logic [DW-1:0] klat_q, klat_d;
  logic [DW-1:0] prev_k_q, prev_k_d;
  logic          sel_q, sel_d;
  logic          hist_q, hist_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          short_q, short_d;

  // Ping-pong tail banks; bank[sel] holds the previous tail, the other receives the current one.
  logic [DW-1:0] bank0 [DEPTH];
  logic [DW-1:0] bank1 [DEPTH];

  logic          accept;
  logic [DW-1:0] k_clamp, k_new, len_eff, k_eff;
  logic          is_end;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [DW-1:0] rd_val, diff, dec;
  logic          wr_en;

  assign s_axis_ready = !m_valid_q || m_axis_ready;
  assign accept       = s_axis_valid && s_axis_ready;

  assign m_axis_data  = m_data_q;
  assign m_axis_valid = m_valid_q;
  assign m_axis_last  = m_last_q;
  assign short_pkt    = short_q;

  // Per-packet parameters: live inputs at position 0, latched copies afterwards.
  always_comb begin
    k_clamp = (32'(k) > DEPTH) ? DW'(DEPTH) : k;
    k_new   = (k_clamp > packet_length) ? packet_length : k_clamp;
    len_eff = (p_q == '0) ? packet_length : len_q;
    k_eff   = (p_q == '0) ? k_new : klat_q;
    is_end  = (p_q == len_eff - DW'(1));
  end

  // Decode datapath; the subtraction is mod 2^DW so the widened input's MSB only carries.
  always_comb begin
    rd_idx = AW'(p_q);
    rd_val = sel_q ? bank1[rd_idx] : bank0[rd_idx];
    diff   = DW'(s_axis_data - {1'b0, rd_val});
    dec    = (hist_q && (p_q < prev_k_q)) ? diff : s_axis_data[DW-1:0];
    wr_en  = accept && (p_q >= len_eff - k_eff);
    wr_idx = AW'(len_eff - DW'(1) - p_q);
  end

  // Next-state for position/history tracking and the output register.
  always_comb begin
    p_d       = p_q;
    len_d     = len_q;
    klat_d    = klat_q;
    prev_k_d  = prev_k_q;
    sel_d     = sel_q;
    hist_d    = hist_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    short_d   = 1'b0;
    if (accept) begin
      if (p_q == '0) begin
        len_d  = packet_length;
        klat_d = k_new;
      end
      m_valid_d = 1'b1;
      m_data_d  = dec;
      m_last_d  = is_end || s_axis_last;
      if (is_end) begin
        p_d      = '0;
        sel_d    = ~sel_q;
        prev_k_d = k_eff;
        hist_d   = 1'b1;
      end else if (s_axis_last) begin
        p_d     = '0;
        hist_d  = 1'b0;
        short_d = 1'b1;
      end else begin
        p_d = p_q + DW'(1);
      end
    end else if (m_axis_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q       <= '0;
      len_q     <= '0;
      klat_q    <= '0;
      prev_k_q  <= '0;
      sel_q     <= 1'b0;
      hist_q    <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      p_q       <= p_d;
      len_q     <= len_d;
      klat_q    <= klat_d;
      prev_k_q  <= prev_k_d;
      sel_q     <= sel_d;
      hist_q    <= hist_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      short_q   <= short_d;
    end
  end

  // Tail capture into the bank not being read, stored reversed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (sel_q) bank0[wr_idx] <= dec;
      else       bank1[wr_idx] <= dec;
    end
  end

endmodule

// File: doc/axis_tail_overlap_dec.md
Name: axis_tail_overlap_dec

Overview:
- Inverse of the packet tail-overlap adder used upstream. That adder emits DATA_WIDTH+1-bit samples where the first k samples of each packet carry the reversed last k samples of the previous packet added in.
- This block receives that widened AXI-Stream, subtracts the stored reversed tail of the previously decoded packet, and emits the original DATA_WIDTH-bit samples.
- Sits directly downstream of the adder or its channel, on the receive side.

Parameters:
- DATA_WIDTH, 8, width of decoded samples; input samples are DATA_WIDTH+1 bits.
- DEPTH, 64, maximum overlap length k; the size of each tail-buffer bank.

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- s_axis_data  input  DATA_WIDTH+1  encoded sample
- s_axis_valid  input  1  upstream valid
- s_axis_last  input  1  upstream end of packet
- s_axis_ready  output  1  accept from upstream
- packet_length  input  DATA_WIDTH  samples per packet, L; valid range 1..2^DATA_WIDTH-1
- k  input  DATA_WIDTH  overlap length
- m_axis_data  output  DATA_WIDTH  decoded sample
- m_axis_valid  output  1  output valid
- m_axis_last  output  1  end of decoded packet
- m_axis_ready  input  1  downstream ready
- short_pkt  output  1  one-cycle pulse: s_axis_last seen before position L-1

Behaviour:
- Reset, synchronous, high for one or more cycles:
  - m_axis_valid=0, m_axis_data=0, m_axis_last=0, short_pkt=0.
  - Position counter=0, bank select=0, hist_valid=0, prev_k=0.
  - Buffer contents are don't-care.
  - Reset mid-packet discards the partial packet; the next accepted beat is position 0 of a first packet.
- Handshake:
  - Registered output stage, one beat.
  - s_axis_ready = !m_axis_valid || m_axis_ready, combinational.
  - A beat transfers when s_axis_valid && s_axis_ready.
  - The decoded result appears on m_axis_* in the next cycle, so latency is 1 cycle.
  - Output holds stable while m_axis_valid && !m_axis_ready.
  - Full throughput of 1 beat/cycle when m_axis_ready=1.
- Per-packet latching:
  - At position 0 of each packet, latch L_lat=packet_length and k_lat=min(k, L_lat, DEPTH).
  - packet_length and k changes mid-packet have no effect.
- Position counter p:
  - Increments per accepted beat.
  - Wraps to 0 after p==L_lat-1, or on an accepted beat with s_axis_last=1, whichever comes first.
- Decode for accepted beat at position p:
  - If hist_valid && p<prev_k: out = (s_axis_data - rd_bank[p]) mod 2^DATA_WIDTH. The subtraction is done in DATA_WIDTH+1 bits; keep the low DATA_WIDTH bits.
  - Otherwise: out = s_axis_data[DATA_WIDTH-1:0].
- Tail capture:
  - If p >= L_lat-k_lat, write out (the decoded value) to wr_bank[L_lat-1-p].
  - This stores the tail reversed, so the next packet reads index p.
- Ping-pong banks:
  - Two banks of DEPTH x DATA_WIDTH. rd_bank=bank[sel], wr_bank=bank[~sel].
  - Reads of the previous tail and writes of the current tail never collide, including k_lat > L_lat/2.
- End of packet, on an accepted beat at p==L_lat-1:
  - sel toggles, prev_k<=k_lat, hist_valid<=1.
  - m_axis_last=1 on that output beat.
- Short packet, accepted s_axis_last=1 with p<L_lat-1:
  - m_axis_last=1 on that output beat.
  - short_pkt pulses in the cycle the output beat is registered.
  - hist_valid<=0, so the next packet passes through undecoded. sel does not toggle.
- s_axis_last=0 at p==L_lat-1: the packet still ends by count; m_axis_last=1 regardless.
- L_lat=1: every beat is a full packet; p stays 0.
- k=0: pure pass-through with truncation; hist_valid still tracks.
- k>DEPTH: clamped to DEPTH.

Test Plan:
- L=4, k=2; inputs 1,2,3,4 then 14,23,30,40 -> outputs 1,2,3,4 (last on 4) then 10,20,30,40 (last on 40).
- L=4, k=3, the overlap exceeds L/2; inputs 1,2,3,4 then 14,23,32,40 -> outputs 1,2,3,4 then 10,20,30,40; checks the ping-pong.
- Modular subtract, DATA_WIDTH=8, L=2, k=1; packet 0 = 5,255; then input 0x1FE -> output 0xFF (510-255=255). Input 0x003 -> output 4 ((3-255) mod 256).
- Backpressure, L=4, k=2, case 1 with m_axis_ready=0 for 3 cycles at the 2nd output beat -> s_axis_ready=0 during the stall, output held, the same data sequence delivered, no drops or duplicates.
- Short packet, L=4; s_axis_last on the 2nd beat -> short_pkt=1 for one cycle, m_axis_last on beat 2; the next packet 7,8,9,10 outputs unchanged.
- Reset asserted for 1 cycle mid-packet (after 2 beats of packet 1) -> outputs idle next cycle; the following packet is treated as first: 14,23,30,40 -> 14,23,30,40.
